// File: rtl/axi_riscv_resv_pkg.sv
// Shared constants and helpers for the LR/SC reservation table.
package axi_riscv_resv_pkg;

   localparam int unsigned TIMEOUT_DISABLED = 0;
   localparam int unsigned MAX_ADDR_WIDTH   = 128;

   typedef logic [MAX_ADDR_WIDTH-1:0] addr_ext_t;

   // Two addresses share a granule when they agree above the ignored low bits.
   function automatic logic granule_match(
      input addr_ext_t   a,
      input addr_ext_t   b,
      input int unsigned addr_lsb
   );
      addr_ext_t diff;
      diff = (a ^ b) >> addr_lsb;
      return diff == '0;
   endfunction

endpackage

// File: rtl/axi_riscv_resv_entry.sv
// One reservation slot: holds issuer ID, reserved address and lifetime timer,
// and reports how it matches the current LR, SC and plain-write addresses.
module axi_riscv_resv_entry
   import axi_riscv_resv_pkg::*;
#(
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned ADDR_LSB       = 3,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DISABLED
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [ID_WIDTH-1:0]   lr_id_i,
   input  logic [ADDR_WIDTH-1:0] lr_addr_i,
   input  logic [ID_WIDTH-1:0]   sc_id_i,
   input  logic [ADDR_WIDTH-1:0] sc_addr_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   output logic                  valid_o,
   output logic                  expire_o,
   output logic                  lr_id_hit_o,
   output logic                  sc_id_hit_o,
   output logic                  sc_gran_hit_o,
   output logic                  wr_gran_hit_o
);

   localparam int unsigned TIMER_WIDTH =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic                  valid_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
      end else if (load_i) begin
         // Install wins over any invalidation in the same cycle.
         valid_q <= 1'b1;
         id_q    <= lr_id_i;
         addr_q  <= lr_addr_i;
      end else if (clear_i || expire_o) begin
         valid_q <= 1'b0;
      end
   end

   generate
      if (TIMEOUT_CYCLES != TIMEOUT_DISABLED) begin : g_timer
         logic [TIMER_WIDTH-1:0] timer_q;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               timer_q <= '0;
            end else if (load_i) begin
               timer_q <= TIMER_WIDTH'(TIMEOUT_CYCLES);
            end else if (valid_q && (timer_q != '0)) begin
               timer_q <= timer_q - 1'b1;
            end
         end

         // Last live cycle: the entry drops on the coming edge.
         assign expire_o = valid_q && (timer_q == TIMER_WIDTH'(1));
      end else begin : g_no_timer
         assign expire_o = 1'b0;
      end
   endgenerate

   assign valid_o       = valid_q;
   assign lr_id_hit_o   = valid_q && (id_q == lr_id_i);
   assign sc_id_hit_o   = valid_q && (id_q == sc_id_i);
   assign sc_gran_hit_o = valid_q &&
      granule_match(addr_ext_t'(addr_q), addr_ext_t'(sc_addr_i), ADDR_LSB);
   assign wr_gran_hit_o = valid_q &&
      granule_match(addr_ext_t'(addr_q), addr_ext_t'(wr_addr_i), ADDR_LSB);

endmodule

// File: rtl/axi_riscv_resv_table.sv
// Shared LR/SC reservation table: ID-keyed entries, round-robin eviction,
// optional lifetime, and a registered back-pressurable SC result.
module axi_riscv_resv_table
   import axi_riscv_resv_pkg::*;
#(
   parameter int unsigned NUM_RESV       = 4,
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned ADDR_LSB       = 3,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DISABLED
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          lr_valid_i,
   input  logic [ID_WIDTH-1:0]           lr_id_i,
   input  logic [ADDR_WIDTH-1:0]         lr_addr_i,
   input  logic                          sc_valid_i,
   output logic                          sc_ready_o,
   input  logic [ID_WIDTH-1:0]           sc_id_i,
   input  logic [ADDR_WIDTH-1:0]         sc_addr_i,
   output logic                          sc_resp_valid_o,
   input  logic                          sc_resp_ready_i,
   output logic                          sc_resp_ok_o,
   output logic [ID_WIDTH-1:0]           sc_resp_id_o,
   input  logic                          wr_valid_i,
   input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
   output logic [$clog2(NUM_RESV+1)-1:0] occupancy_o
);

   localparam int unsigned OCC_WIDTH = $clog2(NUM_RESV + 1);
   localparam int unsigned PTR_WIDTH = (NUM_RESV > 1) ? $clog2(NUM_RESV) : 1;

   logic [NUM_RESV-1:0]  valid;
   logic [NUM_RESV-1:0]  expire;
   logic [NUM_RESV-1:0]  lr_id_hit;
   logic [NUM_RESV-1:0]  sc_id_hit;
   logic [NUM_RESV-1:0]  sc_gran_hit;
   logic [NUM_RESV-1:0]  wr_gran_hit;
   logic [NUM_RESV-1:0]  clear;
   logic [NUM_RESV-1:0]  survive;
   logic [NUM_RESV-1:0]  own_hit;
   logic [NUM_RESV-1:0]  load;
   logic [NUM_RESV-1:0]  next_valid;

   logic                 sc_accept;
   logic                 sc_ok;
   logic                 wr_hits_sc;
   logic                 free_found;
   logic [PTR_WIDTH-1:0] free_idx;
   logic [PTR_WIDTH-1:0] victim_q;
   logic [PTR_WIDTH-1:0] victim_d;
   logic [OCC_WIDTH-1:0] occ_d;

   for (genvar g = 0; g < NUM_RESV; g++) begin : g_entry
      axi_riscv_resv_entry #(
         .ID_WIDTH       (ID_WIDTH),
         .ADDR_WIDTH     (ADDR_WIDTH),
         .ADDR_LSB       (ADDR_LSB),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_entry (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .clear_i       (clear[g]),
         .load_i        (load[g]),
         .lr_id_i       (lr_id_i),
         .lr_addr_i     (lr_addr_i),
         .sc_id_i       (sc_id_i),
         .sc_addr_i     (sc_addr_i),
         .wr_addr_i     (wr_addr_i),
         .valid_o       (valid[g]),
         .expire_o      (expire[g]),
         .lr_id_hit_o   (lr_id_hit[g]),
         .sc_id_hit_o   (sc_id_hit[g]),
         .sc_gran_hit_o (sc_gran_hit[g]),
         .wr_gran_hit_o (wr_gran_hit[g])
      );
   end

   assign sc_ready_o = !sc_resp_valid_o || sc_resp_ready_i;
   assign sc_accept  = sc_valid_i && sc_ready_o;

   // A plain write in the same cycle beats the SC to its granule.
   assign wr_hits_sc = wr_valid_i &&
      granule_match(addr_ext_t'(wr_addr_i), addr_ext_t'(sc_addr_i), ADDR_LSB);
   assign sc_ok      = (|(sc_id_hit & sc_gran_hit)) && !wr_hits_sc;

   assign clear   = ({NUM_RESV{wr_valid_i}} & wr_gran_hit)
                  | ({NUM_RESV{sc_accept}} &
                     (sc_id_hit | ({NUM_RESV{sc_ok}} & sc_gran_hit)));
   assign survive = valid & ~clear & ~expire;
   assign own_hit = lr_id_hit & survive;

   // Lowest-index slot left free once this cycle's invalidations apply.
   always_comb begin
      // NOTE: defaults come first so no path leaves a variable unassigned,
      // which would otherwise infer a latch.
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_RESV - 1; i >= 0; i--) begin
         if (!survive[i]) begin
            free_found = 1'b1;
            free_idx   = PTR_WIDTH'(i);
         end
      end
   end

   always_comb begin
      load     = '0;
      victim_d = victim_q;
      if (lr_valid_i) begin
         if (|own_hit) begin
            load = own_hit;
         end else if (free_found) begin
            load[free_idx] = 1'b1;
         end else begin
            load[victim_q] = 1'b1;
            victim_d = (victim_q == PTR_WIDTH'(NUM_RESV - 1)) ? '0
                                                             : victim_q + 1'b1;
         end
      end
   end

   assign next_valid = survive | load;

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < NUM_RESV; i++) begin
         occ_d = occ_d + OCC_WIDTH'(next_valid[i]);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         victim_q    <= '0;
         occupancy_o <= '0;
      end else begin
         victim_q    <= victim_d;
         occupancy_o <= occ_d;
      end
   end

   // Result register: loads on acceptance, otherwise drains when consumed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sc_resp_valid_o <= 1'b0;
         sc_resp_ok_o    <= 1'b0;
         sc_resp_id_o    <= '0;
      end else if (sc_accept) begin
         sc_resp_valid_o <= 1'b1;
         sc_resp_ok_o    <= sc_ok;
         sc_resp_id_o    <= sc_id_i;
      end else if (sc_resp_ready_i) begin
         sc_resp_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_riscv_resv_table.sv
// Bench for axi_riscv_resv_table: directed scenarios plus random traffic
// checked against a behavioural table model.
module tb_axi_riscv_resv_table;

   localparam int unsigned N   = 4;
   localparam int unsigned IW  = 4;
   localparam int unsigned AW  = 64;
   localparam int unsigned LSB = 3;
   localparam int unsigned TO  = 8;
   localparam int unsigned OW  = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lr_valid, sc_valid, wr_valid, sc_resp_ready;
   logic [IW-1:0] lr_id, sc_id;
   logic [AW-1:0] lr_addr, sc_addr, wr_addr;
   logic          sc_ready, sc_resp_valid, sc_resp_ok;
   logic [IW-1:0] sc_resp_id;
   logic [OW-1:0] occupancy;

   axi_riscv_resv_table #(
      .NUM_RESV       (N),
      .ID_WIDTH       (IW),
      .ADDR_WIDTH     (AW),
      .ADDR_LSB       (LSB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .lr_valid_i      (lr_valid),
      .lr_id_i         (lr_id),
      .lr_addr_i       (lr_addr),
      .sc_valid_i      (sc_valid),
      .sc_ready_o      (sc_ready),
      .sc_id_i         (sc_id),
      .sc_addr_i       (sc_addr),
      .sc_resp_valid_o (sc_resp_valid),
      .sc_resp_ready_i (sc_resp_ready),
      .sc_resp_ok_o    (sc_resp_ok),
      .sc_resp_id_o    (sc_resp_id),
      .wr_valid_i      (wr_valid),
      .wr_addr_i       (wr_addr),
      .occupancy_o     (occupancy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: a list of reservations with remaining lifetimes.
   bit            m_valid [N];
   logic [IW-1:0] m_id    [N];
   logic [AW-1:0] m_gran  [N];
   int            m_life  [N];
   int            m_victim;
   bit            m_rv, m_rok, m_acc;
   logic [IW-1:0] m_rid;

   function automatic int m_occ();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_id[i] = '0; m_gran[i] = '0; m_life[i] = 0;
      end
      m_victim = 0; m_rv = 0; m_rok = 0; m_rid = '0; m_acc = 0;
   endtask

   task automatic model_step();
      logic [AW-1:0] sg, wg, lg;
      bit ok, kill;
      int slot;
      sg = sc_addr >> LSB;
      wg = wr_addr >> LSB;
      lg = lr_addr >> LSB;
      m_acc = sc_valid && (!m_rv || sc_resp_ready);
      ok = 0;
      for (int i = 0; i < N; i++)
         if (m_valid[i] && m_id[i] == sc_id && m_gran[i] == sg) ok = 1;
      if (wr_valid && wg == sg) ok = 0;
      for (int i = 0; i < N; i++) begin
         kill = (TO != 0 && m_life[i] == 1)
             || (wr_valid && m_gran[i] == wg)
             || (m_acc && m_id[i] == sc_id)
             || (m_acc && ok && m_gran[i] == sg);
         if (kill) m_valid[i] = 0;
         m_life[i] = m_life[i] - 1;
      end
      if (lr_valid) begin
         slot = -1;
         for (int i = 0; i < N; i++) if (m_valid[i] && m_id[i] == lr_id) slot = i;
         if (slot < 0)
            for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
         if (slot < 0) begin
            slot = m_victim;
            m_victim = (m_victim + 1) % N;
         end
         m_valid[slot] = 1; m_id[slot] = lr_id; m_gran[slot] = lg; m_life[slot] = TO;
      end
      if (m_acc) begin
         m_rv = 1; m_rok = ok; m_rid = sc_id;
      end else if (sc_resp_ready) begin
         m_rv = 0;
      end
   endtask

   task automatic tick();
      if (rst) model_reset();
      else     model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      lr_valid = 0; lr_id = '0; lr_addr = '0;
      sc_valid = 0; sc_id = '0; sc_addr = '0;
      wr_valid = 0; wr_addr = '0;
      sc_resp_ready = 1;
   endtask

   task automatic do_lr(input int id, input logic [AW-1:0] addr);
      idle(); lr_valid = 1; lr_id = IW'(id); lr_addr = addr;
      tick(); idle();
   endtask

   task automatic do_sc(input int id, input logic [AW-1:0] addr);
      idle(); sc_valid = 1; sc_id = IW'(id); sc_addr = addr;
      tick(); idle();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return (AW'($urandom_range(0, 7)) << LSB) | AW'($urandom_range(0, 7));
   endfunction

   task automatic test_reset();
      idle(); rst = 1; model_reset();
      tick(); tick();
      vectors++;
      if (sc_resp_valid !== 1'b0 || sc_resp_ok !== 1'b0 || sc_resp_id !== '0 ||
          occupancy !== '0 || sc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b ok=%b id=%0d occ=%0d ready=%b, want 0 0 0 0 1",
                  sc_resp_valid, sc_resp_ok, sc_resp_id, occupancy, sc_ready);
      end
      rst = 0;
   endtask

   task automatic test_basic_sc();
      do_lr(1, 64'h1000);
      vectors++;
      if (occupancy !== OW'(1) || sc_resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_lr: occ=%0d valid=%b, want 1 0", occupancy, sc_resp_valid);
      end
      do_sc(1, 64'h1004);
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b1 || sc_resp_id !== IW'(1) ||
          occupancy !== OW'(0)) begin
         miscompares++;
         $display("FAIL basic_sc: valid=%b ok=%b id=%0d occ=%0d, want 1 1 1 0",
                  sc_resp_valid, sc_resp_ok, sc_resp_id, occupancy);
      end
      tick();
      vectors++;
      if (sc_resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_drain: valid=%b, want 0", sc_resp_valid);
      end
   endtask

   task automatic test_write_kill();
      do_lr(1, 64'h1000);
      wr_valid = 1; wr_addr = 64'h1000; tick(); idle();
      vectors++;
      if (occupancy !== OW'(0)) begin
         miscompares++;
         $display("FAIL write_clears: occ=%0d, want 0", occupancy);
      end
      do_sc(1, 64'h1000);
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b0 || sc_resp_id !== IW'(1)) begin
         miscompares++;
         $display("FAIL sc_after_write: valid=%b ok=%b id=%0d, want 1 0 1",
                  sc_resp_valid, sc_resp_ok, sc_resp_id);
      end
      do_lr(1, 64'h1000);
      sc_valid = 1; sc_id = IW'(1); sc_addr = 64'h1000;
      wr_valid = 1; wr_addr = 64'h1000;
      tick(); idle();
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b0 || occupancy !== OW'(0)) begin
         miscompares++;
         $display("FAIL sc_same_cycle_write: valid=%b ok=%b occ=%0d, want 1 0 0",
                  sc_resp_valid, sc_resp_ok, occupancy);
      end
      tick();
   endtask

   task automatic test_eviction();
      for (int i = 0; i < 5; i++) do_lr(i, AW'(i) << 8);
      vectors++;
      if (occupancy !== OW'(4)) begin
         miscompares++;
         $display("FAIL evict_occ: occ=%0d, want 4", occupancy);
      end
      do_sc(0, 64'h0);
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b0 || sc_resp_id !== IW'(0)) begin
         miscompares++;
         $display("FAIL evicted_sc: valid=%b ok=%b id=%0d, want 1 0 0",
                  sc_resp_valid, sc_resp_ok, sc_resp_id);
      end
      do_sc(4, 64'h400);
      vectors++;
      if (sc_resp_ok !== 1'b1 || sc_resp_id !== IW'(4) || occupancy !== OW'(3)) begin
         miscompares++;
         $display("FAIL newest_sc: ok=%b id=%0d occ=%0d, want 1 4 3",
                  sc_resp_ok, sc_resp_id, occupancy);
      end
      repeat (10) tick();
      vectors++;
      if (occupancy !== OW'(0)) begin
         miscompares++;
         $display("FAIL evict_drain: occ=%0d, want 0", occupancy);
      end
   endtask

   task automatic test_timeout();
      do_lr(2, 64'h2000);
      repeat (7) tick();
      vectors++;
      if (occupancy !== OW'(1)) begin
         miscompares++;
         $display("FAIL timeout_alive: occ=%0d, want 1", occupancy);
      end
      do_sc(2, 64'h2000);
      vectors++;
      if (sc_resp_ok !== 1'b1 || sc_resp_id !== IW'(2)) begin
         miscompares++;
         $display("FAIL sc_cycle7: ok=%b id=%0d, want 1 2", sc_resp_ok, sc_resp_id);
      end
      do_lr(2, 64'h2000);
      repeat (9) tick();
      vectors++;
      if (occupancy !== OW'(0)) begin
         miscompares++;
         $display("FAIL timeout_expired: occ=%0d, want 0", occupancy);
      end
      do_sc(2, 64'h2000);
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b0) begin
         miscompares++;
         $display("FAIL sc_cycle9: valid=%b ok=%b, want 1 0", sc_resp_valid, sc_resp_ok);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_lr(3, 64'h3000);
      do_lr(5, 64'h5000);
      sc_valid = 1; sc_id = IW'(3); sc_addr = 64'h3000; sc_resp_ready = 0;
      tick();
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b1 || sc_resp_id !== IW'(3)) begin
         miscompares++;
         $display("FAIL bp_first: valid=%b ok=%b id=%0d, want 1 1 3",
                  sc_resp_valid, sc_resp_ok, sc_resp_id);
      end
      sc_id = IW'(5); sc_addr = 64'h5000;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (sc_ready !== 1'b0 || sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b1 ||
             sc_resp_id !== IW'(3) || occupancy !== OW'(1)) begin
            miscompares++;
            $display("FAIL bp_stall%0d: ready=%b valid=%b ok=%b id=%0d occ=%0d, want 0 1 1 3 1",
                     c, sc_ready, sc_resp_valid, sc_resp_ok, sc_resp_id, occupancy);
         end
      end
      sc_resp_ready = 1;
      #1;
      vectors++;
      if (sc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release_ready: ready=%b, want 1", sc_ready);
      end
      tick(); idle();
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b1 || sc_resp_id !== IW'(5) ||
          occupancy !== OW'(0)) begin
         miscompares++;
         $display("FAIL bp_second: valid=%b ok=%b id=%0d occ=%0d, want 1 1 5 0",
                  sc_resp_valid, sc_resp_ok, sc_resp_id, occupancy);
      end
      tick();
   endtask

   task automatic test_random();
      bit pend;
      idle();
      for (int c = 0; c < 400; c++) begin
         pend     = sc_valid && !m_acc;
         lr_valid = ($urandom_range(0, 9) < 3);
         lr_id    = IW'($urandom_range(0, 7));
         lr_addr  = rand_addr();
         wr_valid = ($urandom_range(0, 9) < 2);
         wr_addr  = rand_addr();
         if (!pend) begin
            sc_valid = ($urandom_range(0, 9) < 4);
            sc_id    = IW'($urandom_range(0, 7));
            sc_addr  = rand_addr();
         end
         sc_resp_ready = ($urandom_range(0, 9) < 7);
         #1;
         vectors++;
         if (sc_ready !== (!m_rv || sc_resp_ready)) begin
            miscompares++;
            $display("FAIL rand_ready c=%0d: got %b want %b", c, sc_ready, !m_rv || sc_resp_ready);
         end
         tick();
         vectors++;
         if (sc_resp_valid !== m_rv || sc_resp_ok !== m_rok || sc_resp_id !== m_rid) begin
            miscompares++;
            $display("FAIL rand_resp c=%0d: got v=%b ok=%b id=%0d want v=%b ok=%b id=%0d",
                     c, sc_resp_valid, sc_resp_ok, sc_resp_id, m_rv, m_rok, m_rid);
         end
         vectors++;
         if (occupancy !== OW'(m_occ())) begin
            miscompares++;
            $display("FAIL rand_occ c=%0d: got %0d want %0d", c, occupancy, m_occ());
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      idle();
      repeat (10) tick();
      for (int i = 0; i < 3; i++) do_lr(6 + i, 64'h6000 + (AW'(i) << 8));
      sc_valid = 1; sc_id = IW'(9); sc_addr = 64'h9000; sc_resp_ready = 0;
      tick();
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_id !== IW'(9) || occupancy !== OW'(3)) begin
         miscompares++;
         $display("FAIL pre_reset: valid=%b id=%0d occ=%0d, want 1 9 3",
                  sc_resp_valid, sc_resp_id, occupancy);
      end
      rst = 1;
      #1;
      vectors++;
      if (sc_resp_valid !== 1'b0 || sc_resp_ok !== 1'b0 || sc_resp_id !== '0 ||
          occupancy !== '0 || sc_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset: valid=%b ok=%b id=%0d occ=%0d ready=%b, want 0 0 0 0 1",
                  sc_resp_valid, sc_resp_ok, sc_resp_id, occupancy, sc_ready);
      end
      idle();
      tick();
      rst = 0;
      do_sc(6, 64'h6000);
      vectors++;
      if (sc_resp_valid !== 1'b1 || sc_resp_ok !== 1'b0 || sc_resp_id !== IW'(6)) begin
         miscompares++;
         $display("FAIL sc_after_reset: valid=%b ok=%b id=%0d, want 1 0 6",
                  sc_resp_valid, sc_resp_ok, sc_resp_id);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_sc();
      test_write_kill();
      test_eviction();
      test_timeout();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
